leve1_axir_arb: RTL and testbench
=================================

// Module: leve1_axir_arb
// PURPOSE
//  Shares one AXIR read-initiator port to memory between two requesters: instruction fetch (RII) and data load (RID).
//  Sits between the core and the memory/bus, so LEVE1 can add a load/store path without a second memory port.
//  Keeps one transaction outstanding, arbitrates round-robin and locks the grant until the last R beat.
// PARAMETERS
//  STARVE_MAX  4  max consecutive RID grants while RII waits (used only when LEVE1_ARB_DPRIO_EN is defined)
// PORTS
//  CLK    in   1         clock; all state changes on posedge CLK
//  RST    in   1         reset, synchronous, active-high
//  RII    AXIR.target    instruction requester (AR*/R* fields, `XLEN address/data)
//  RID    AXIR.target    data requester, same field set
//  RIM    AXIR.init      shared memory-side initiator
//  GNT_D  out  1         debug: current or last grant is RID
//  BUSY   out  1         debug: FSM not in IDLE
// BEHAVIOUR
//  Reset (RST=1 at posedge): FSM=IDLE, rr_ptr=RII, RIM.ARVALID=0, RII/RID.ARREADY=0.
//   RII/RID.RVALID=0, GNT_D=0, BUSY=0, starve_cnt=0.
//  FSM states: IDLE -> AR -> R -> IDLE.
//  IDLE:
//   - Pick a winner among asserted ARVALIDs. One requester: it wins.
//     Both: the one that is not rr_ptr wins; rr_ptr holds the last winner (reset value = RII, so RID wins the first tie).
//   - Drive winner ARREADY=1 combinationally in the same cycle; the loser sees ARREADY=0.
//   - On handshake: latch ARADDR (plus ARLEN/ARSIZE if present), set grant and rr_ptr=winner, go to AR.
//  AR:
//   - RIM.ARVALID=1 with latched fields, held stable until RIM.ARREADY; then go to R.
//   - Requester-to-memory AR latency is 1 cycle minimum.
//  R:
//   - Route RIM.RVALID/RDATA/RRESP/RLAST combinationally to the granted requester.
//   - RIM.RREADY = granted requester's RREADY. Non-granted RVALID=0.
//   - Zero added R latency.
//   - On RVALID&RREADY&RLAST: go to IDLE. The next grant is possible the following cycle (no back-to-back AR in that same cycle).
//  ARREADY to both requesters is 0 outside IDLE. A new ARVALID held during AR/R waits and is not dropped.
//  Requesters must hold ARVALID/ARADDR until ARREADY (AXI rule). The arbiter never retracts RIM.ARVALID once asserted.
//  Mid-transaction RST: abandon the transaction, return to IDLE. Memory side shares RST, so no stale beats are expected.
//  RLAST seen when not in R, or an R beat when no grant is active: the beat is ignored.
//   RIM.RREADY=1 in IDLE to drain it; an assertion flags it in simulation.
// CONFIGURATION
//  LEVE1_ARB_DPRIO_EN defined:
//   - Fixed priority RID > RII instead of round-robin.
//   - starve_cnt (clog2(STARVE_MAX+1) bits) counts RID grants made while RII.ARVALID=1. It clears on any RII grant.
//   - When starve_cnt==STARVE_MAX and RII.ARVALID=1, RII wins regardless.
//  Undefined: pure round-robin as above; starve_cnt and STARVE_MAX are unused and optimised away.
// STRUCTURE
//  Shared package leve1_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_AR, ARB_R} arb_state_t.
//   Also typedef enum logic {REQ_I, REQ_D} arb_req_t.
//  One sub-module leve1_rr_arb2: 2-input round-robin pick (req[1:0], ptr, en) -> gnt.
//   It is combinational with the ptr register inside. The FSM, latch and R mux stay in the top.
// TESTING
//  1. RII ARVALID addr=0x100 alone:
//     - RII.ARREADY in the same cycle; RIM.ARVALID with 0x100 next cycle.
//     - RDATA 0xDEADBEEF+RLAST is delivered only to RII; BUSY drops the cycle after.
//  2. RII and RID both ARVALID after reset: RID granted first.
//     RII is granted in the IDLE cycle after RID's RLAST; grants then alternate I,D,I,D over 4 back-to-back requests.
//  3. RIM.ARREADY held low 5 cycles: RIM.ARVALID and ARADDR stay stable for all 5; no R routing before AR handshake.
//  4. RII.RREADY=0 for 3 cycles during R: RIM.RREADY=0 for those cycles; the beat completes on the first RREADY=1.
//  5. RST=1 while in R with RID granted: next cycle BUSY=0, all ARREADY/RVALID=0, rr_ptr=RII.
//     Then a simultaneous request grants RID.
//  6. With LEVE1_ARB_DPRIO_EN, STARVE_MAX=4, both requesting continuously: grant pattern D,D,D,D,I repeats.
//     Without the macro, the pattern is D,I,D,I.

Source files
------------

// File: rtl/leve1_pkg.sv
// Shared types for the LEVE1 read-port arbiter: FSM states and requester identifiers.
`ifndef XLEN
`define XLEN 32
`endif

package leve1_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_AR, ARB_R} arb_state_t;

  typedef enum logic {REQ_I, REQ_D} arb_req_t;

endpackage

// File: rtl/leve1_axir.sv
// AXIR read-channel bundle: AR request channel plus R data channel, `XLEN wide.
`ifndef XLEN
`define XLEN 32
`endif

interface AXIR;
  logic             ARVALID;
  logic             ARREADY;
  logic [`XLEN-1:0] ARADDR;
  logic             RVALID;
  logic             RREADY;
  logic [`XLEN-1:0] RDATA;
  logic [1:0]       RRESP;
  logic             RLAST;

  modport target (input ARVALID, ARADDR, RREADY, output ARREADY, RVALID, RDATA, RRESP, RLAST);
  modport init   (output ARVALID, ARADDR, RREADY, input ARREADY, RVALID, RDATA, RRESP, RLAST);
endinterface

// File: rtl/leve1_rr_arb2.sv
// Two-input round-robin pick; bit 0 is instruction fetch, bit 1 is data load.
// ptr remembers the last winner so that a tie goes to the other requester.
module leve1_rr_arb2
  import leve1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  arb_req_t ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= REQ_I;
    end else if (en && (|gnt)) begin
      ptr <= gnt[1] ? REQ_D : REQ_I;
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr == REQ_I) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/leve1_axir_arb.sv
// Shares one AXIR read port between instruction fetch (RII) and data load (RID), one transaction at a time.
// Define LEVE1_ARB_DPRIO_EN for fixed RID priority with an RII starvation limit of STARVE_MAX grants.
module leve1_axir_arb
  import leve1_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic RST,
  AXIR.target  RII,
  AXIR.target  RID,
  AXIR.init    RIM,
  output logic GNT_D,
  output logic BUSY
);

  arb_state_t       state;
  arb_state_t       state_next;
  arb_req_t         grant;
  arb_req_t         winner;
  logic [`XLEN-1:0] addr_q;
  logic [1:0]       req;
  logic [1:0]       pick;
  logic             take;

  assign req    = {RID.ARVALID, RII.ARVALID};
  assign take   = (state == ARB_IDLE) && (|pick);
  assign winner = pick[1] ? REQ_D : REQ_I;

`ifdef LEVE1_ARB_DPRIO_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;

  // RID normally wins; RII is forced through once it has waited STARVE_MAX grants.
  always_comb begin
    pick = 2'b00;
    if (req[0] && (starve_cnt == CNT_W'(STARVE_MAX))) begin
      pick = 2'b01;
    end else if (req[1]) begin
      pick = 2'b10;
    end else if (req[0]) begin
      pick = 2'b01;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (winner == REQ_I) begin
        starve_cnt <= '0;
      end else if (req[0]) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  leve1_rr_arb2 u_rr (
    .clk (CLK),
    .rst (RST),
    .req (req),
    .en  (take),
    .gnt (pick)
  );

  // The starvation limit only shapes the priority build.
  if (STARVE_MAX == 0) begin : g_no_starve_limit
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ARB_IDLE;
      grant  <= REQ_I;
      addr_q <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        grant  <= winner;
        addr_q <= (winner == REQ_D) ? RID.ARADDR : RII.ARADDR;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (take) state_next = ARB_AR;
      ARB_AR:   if (RIM.ARREADY) state_next = ARB_R;
      ARB_R:    if (RIM.RVALID && RIM.RREADY && RIM.RLAST) state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Data fields fan out to both requesters; only the granted one ever sees RVALID.
  always_comb begin
    RII.ARREADY = 1'b0;
    RID.ARREADY = 1'b0;
    RII.RVALID  = 1'b0;
    RID.RVALID  = 1'b0;
    RII.RDATA   = RIM.RDATA;
    RID.RDATA   = RIM.RDATA;
    RII.RRESP   = RIM.RRESP;
    RID.RRESP   = RIM.RRESP;
    RII.RLAST   = RIM.RLAST;
    RID.RLAST   = RIM.RLAST;
    RIM.ARVALID = (state == ARB_AR);
    RIM.ARADDR  = addr_q;
    RIM.RREADY  = 1'b0;
    case (state)
      ARB_IDLE: begin
        RII.ARREADY = take && (winner == REQ_I);
        RID.ARREADY = take && (winner == REQ_D);
        RIM.RREADY  = 1'b1;
      end
      ARB_R: begin
        if (grant == REQ_D) begin
          RID.RVALID = RIM.RVALID;
          RIM.RREADY = RID.RREADY;
        end else begin
          RII.RVALID = RIM.RVALID;
          RIM.RREADY = RII.RREADY;
        end
      end
      default: ;
    endcase
  end

  assign GNT_D = (grant == REQ_D);
  assign BUSY  = (state != ARB_IDLE);

`ifndef SYNTHESIS
  // A beat outside R has no owner; it is drained and flagged here.
  stray_beat: assert property (@(posedge CLK) disable iff (RST) !(RIM.RVALID && (state != ARB_R)));
`endif

endmodule

// File: tb/tb_leve1_axir_arb.sv
// Scoreboard bench for leve1_axir_arb: expected grants are queued when requests are raised.
module tb_leve1_axir_arb;
  import leve1_pkg::*;

  typedef struct {
    logic        isD;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic CLK = 1'b0;
  logic RST;
  logic GNT_D;
  logic BUSY;
  int   checks = 0;
  int   errors = 0;
  txn_t sb[$];
  logic seq[6];

  AXIR rii();
  AXIR rid();
  AXIR rim();

  leve1_axir_arb #(.STARVE_MAX(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .RII   (rii),
    .RID   (rid),
    .RIM   (rim),
    .GNT_D (GNT_D),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic isD, input logic valid, input logic [31:0] addr);
    if (isD) begin
      rid.ARVALID = valid;
      rid.ARADDR  = addr;
    end else begin
      rii.ARVALID = valid;
      rii.ARADDR  = addr;
    end
  endtask

  task automatic setRready(input logic isD, input logic value);
    if (isD) rid.RREADY = value;
    else     rii.RREADY = value;
  endtask

  task automatic pushExp(input logic isD, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.isD  = isD;
    t.addr = addr;
    t.data = data;
    sb.push_back(t);
  endtask

  task automatic resetDut();
    @(negedge CLK);
    RST = 1'b1;
    rii.ARVALID = 1'b0;
    rid.ARVALID = 1'b0;
    rim.ARREADY = 1'b0;
    rim.RVALID  = 1'b0;
    rim.RLAST   = 1'b0;
    rii.RREADY  = 1'b1;
    rid.RREADY  = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  // Entered just after a negedge with the arbiter idle and the expected winner requesting.
  task automatic runTxn(input int arStall, input int rStall, input logic keep);
    txn_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    checkOutput("idle_busy", BUSY, 0);
    checkOutput("arready_win", e.isD ? rid.ARREADY : rii.ARREADY, 1);
    checkOutput("arready_lose", e.isD ? rii.ARREADY : rid.ARREADY, 0);
    @(negedge CLK);
    if (!keep) applyStimulus(e.isD, 1'b0, e.addr);
    #1;
    checkOutput("rim_arvalid", rim.ARVALID, 1);
    checkOutput("rim_araddr", rim.ARADDR, e.addr);
    checkOutput("busy_ar", BUSY, 1);
    checkOutput("gnt_d", GNT_D, e.isD);
    checkOutput("arready_ar", {rii.ARREADY, rid.ARREADY}, 0);
    for (int i = 0; i < arStall; i++) begin
      @(negedge CLK);
      #1;
      checkOutput("ar_stall_valid", rim.ARVALID, 1);
      checkOutput("ar_stall_addr", rim.ARADDR, e.addr);
      checkOutput("ar_stall_rvalid", {rii.RVALID, rid.RVALID}, 0);
    end
    rim.ARREADY = 1'b1;
    @(negedge CLK);
    rim.ARREADY = 1'b0;
    rim.RVALID  = 1'b1;
    rim.RDATA   = e.data;
    rim.RRESP   = 2'b00;
    rim.RLAST   = 1'b1;
    if (rStall > 0) setRready(e.isD, 1'b0);
    #1;
    checkOutput("rim_arvalid_r", rim.ARVALID, 0);
    for (int i = 0; i < rStall; i++) begin
      checkOutput("rready_stall", rim.RREADY, 0);
      checkOutput("rvalid_stall", e.isD ? rid.RVALID : rii.RVALID, 1);
      @(negedge CLK);
      if (i == rStall - 1) setRready(e.isD, 1'b1);
      #1;
    end
    checkOutput("rim_rready", rim.RREADY, 1);
    checkOutput("rvalid_win", e.isD ? rid.RVALID : rii.RVALID, 1);
    checkOutput("rvalid_lose", e.isD ? rii.RVALID : rid.RVALID, 0);
    checkOutput("rdata", e.isD ? rid.RDATA : rii.RDATA, e.data);
    checkOutput("rlast", e.isD ? rid.RLAST : rii.RLAST, 1);
    @(negedge CLK);
    rim.RVALID = 1'b0;
    rim.RLAST  = 1'b0;
    #1;
    checkOutput("busy_done", BUSY, 0);
  endtask

  initial begin
    RST = 1'b1;
    rii.ARVALID = 1'b0; rii.ARADDR = '0; rii.RREADY = 1'b1;
    rid.ARVALID = 1'b0; rid.ARADDR = '0; rid.RREADY = 1'b1;
    rim.ARREADY = 1'b0; rim.RVALID = 1'b0; rim.RDATA = '0;
    rim.RRESP = 2'b00; rim.RLAST = 1'b0;
`ifdef LEVE1_ARB_DPRIO_EN
    seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif

    resetDut();
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_gnt_d", GNT_D, 0);
    checkOutput("rst_rim_arvalid", rim.ARVALID, 0);
    checkOutput("rst_rim_rready", rim.RREADY, 1);
    checkOutput("rst_arready", {rii.ARREADY, rid.ARREADY}, 0);
    checkOutput("rst_rvalid", {rii.RVALID, rid.RVALID}, 0);

    $display("[TB] single instruction fetch");
    @(negedge CLK);
    applyStimulus(1'b0, 1'b1, 32'h100);
    pushExp(1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    runTxn(0, 0, 1'b0);

    $display("[TB] simultaneous requests, back-to-back");
    resetDut();
    @(negedge CLK);
    applyStimulus(1'b0, 1'b1, 32'h200);
    applyStimulus(1'b1, 1'b1, 32'h300);
    for (int i = 0; i < 6; i++) begin
      pushExp(seq[i], seq[i] ? 32'h300 : 32'h200, 32'h5A5A_0000 + i);
    end
    #1;
    for (int i = 0; i < 6; i++) runTxn(0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h200);
    applyStimulus(1'b1, 1'b0, 32'h300);

    $display("[TB] memory AR backpressure");
    @(negedge CLK);
    applyStimulus(1'b1, 1'b1, 32'h180);
    pushExp(1'b1, 32'h180, 32'hCAFE_0180);
    #1;
    runTxn(4, 0, 1'b0);

    $display("[TB] requester R backpressure");
    @(negedge CLK);
    applyStimulus(1'b0, 1'b1, 32'h1C0);
    pushExp(1'b0, 32'h1C0, 32'hBEEF_01C0);
    #1;
    runTxn(0, 3, 1'b0);

    $display("[TB] reset during R");
    @(negedge CLK);
    applyStimulus(1'b1, 1'b1, 32'h400);
    #1;
    checkOutput("mid_arready", rid.ARREADY, 1);
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 32'h400);
    rim.ARREADY = 1'b1;
    @(negedge CLK);
    rim.ARREADY = 1'b0;
    rim.RVALID  = 1'b1;
    rim.RDATA   = 32'h1234_5678;
    rim.RLAST   = 1'b1;
    rid.RREADY  = 1'b0;
    #1;
    checkOutput("mid_rvalid", rid.RVALID, 1);
    checkOutput("mid_gnt_d", GNT_D, 1);
    @(negedge CLK);
    RST = 1'b1;
    rim.RVALID = 1'b0;
    rim.RLAST  = 1'b0;
    rid.RREADY = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("post_rst_busy", BUSY, 0);
    checkOutput("post_rst_gnt_d", GNT_D, 0);
    checkOutput("post_rst_arready", {rii.ARREADY, rid.ARREADY}, 0);
    checkOutput("post_rst_rvalid", {rii.RVALID, rid.RVALID}, 0);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b1, 32'h500);
    applyStimulus(1'b1, 1'b1, 32'h600);
    pushExp(1'b1, 32'h600, 32'h0000_0600);
    pushExp(1'b0, 32'h500, 32'h0000_0500);
    #1;
    runTxn(0, 0, 1'b0);
    runTxn(0, 0, 1'b0);
    checkOutput("sb_drained", sb.size(), 0);

    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
